// File: rtl/plut_pkg.sv
// Shared definitions for the programmable LUT block: FSM encoding and parameter legality.
package plut_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SWEEP = S_SWEEP,
    ST_DRAIN = S_DRAIN
  } plut_state_e;

  function automatic bit plut_params_ok(int n_in, int n_out);
    return (n_in >= 1) && (n_in <= 8) && (n_out >= 1) && (n_out <= 16);
  endfunction

endpackage

// File: rtl/prog_logic_lut_if.sv
// Config, request and result channels of prog_logic_lut; slave = the block, master = its user.
interface prog_logic_lut_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic             cfg_we;
  logic [N_IN-1:0]  cfg_addr;
  logic [N_OUT-1:0] cfg_data;
  logic             cfg_err;
  logic             in_valid;
  logic [N_IN-1:0]  in_data;
  logic             in_ready;
  logic             sweep_start;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [N_IN-1:0]  out_index;
  logic [N_OUT-1:0] out_data;
  logic             sweep_done;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, sweep_start, out_ready,
    output cfg_err, in_ready, busy, out_valid, out_index, out_data, sweep_done
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, sweep_start, out_ready,
    input  cfg_err, in_ready, busy, out_valid, out_index, out_data, sweep_done
  );
endinterface

// File: rtl/plut_table.sv
// Truth-table store: 2**N_IN entries of N_OUT bits, sync write/clear, async read.
module plut_table #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [N_IN-1:0]  i_waddr,
  input  logic [N_OUT-1:0] i_wdata,
  input  logic [N_IN-1:0]  i_raddr,
  output logic [N_OUT-1:0] o_rdata
);
  localparam int DEPTH = 1 << N_IN;

  logic [DEPTH-1:0][N_OUT-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (!rst_n)    r_mem <= '0;
    else if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read is combinational off the flops, so a same-cycle write is seen only next cycle.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_logic_lut.sv
// Programmable N_IN-in / N_OUT-out logic function with handshaked eval and exhaustive sweep.
module prog_logic_lut
  import plut_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input logic             clk,
  input logic             rst_n,
  prog_logic_lut_if.slave bus
);
  localparam logic [N_IN:0] LAST = {1'b0, {N_IN{1'b1}}};

  if (!plut_params_ok(N_IN, N_OUT)) begin : g_bad_params
    $error("prog_logic_lut: N_IN must be 1..8 and N_OUT 1..16");
  end

  plut_state_e      r_state, w_state_nxt;
  logic [N_IN:0]    r_cnt, w_cnt_nxt;
  logic             r_out_valid;
  logic [N_IN-1:0]  r_out_index;
  logic [N_OUT-1:0] r_out_data;
  logic             r_cfg_err;

  logic             w_can_load, w_pop, w_accept, w_push, w_load;
  logic             w_in_ready, w_sweep_done, w_tbl_we;
  logic [N_IN-1:0]  w_raddr;
  logic [N_OUT-1:0] w_rdata;

  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_pop      = r_out_valid && bus.out_ready;
  assign w_tbl_we   = bus.cfg_we && (r_state == ST_IDLE);

  plut_table #(.N_IN(N_IN), .N_OUT(N_OUT)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_tbl_we),
    .i_waddr (bus.cfg_addr),
    .i_wdata (bus.cfg_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_push       = 1'b0;
    w_in_ready   = 1'b0;
    w_sweep_done = 1'b0;
    w_raddr      = bus.in_data;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = w_can_load;
        w_accept   = bus.in_valid && w_can_load;
        if (bus.sweep_start) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        // Counter only advances on a push, so back-pressure stalls the sweep in place.
        w_raddr = r_cnt[N_IN-1:0];
        if (w_can_load) begin
          w_push    = 1'b1;
          w_cnt_nxt = r_cnt + (N_IN+1)'(1);
          if (r_cnt == LAST) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_pop) begin
          w_sweep_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_load = w_accept || w_push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cfg_err <= bus.cfg_we && (r_state != ST_IDLE);
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_index <= w_raddr;
        r_out_data  <= w_rdata;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Combinational handshake outputs are forced low while reset is asserted.
  assign bus.in_ready   = rst_n && w_in_ready;
  assign bus.sweep_done = rst_n && w_sweep_done;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.cfg_err    = r_cfg_err;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_index  = r_out_index;
  assign bus.out_data   = r_out_data;

endmodule

// File: tb/tb_prog_logic_lut.sv
// Directed + random checks of prog_logic_lut against a queue/array reference model.
module tb_prog_logic_lut;
  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  prog_logic_lut_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  prog_logic_lut #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] idx;
    logic [2:0] data;
    bit         swp;
  } res_t;

  logic [2:0] model [DEPTH];
  res_t       exp_q [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 3'b000;
    exp_q.delete();
  endtask

  // One idle-mode cycle: drive, check against the single-slot queue model, clock.
  task automatic drive_cycle(bit iv, logic [3:0] id, bit ordy, bit we, logic [3:0] wa, logic [2:0] wd);
    bit   exp_rdy, pop, acc;
    res_t r;
    bus.in_valid = iv; bus.in_data = id; bus.out_ready = ordy;
    bus.cfg_we = we; bus.cfg_addr = wa; bus.cfg_data = wd; bus.sweep_start = 1'b0;
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_index", 32'(bus.out_index), 32'(exp_q[0].idx));
      chk("out_data", 32'(bus.out_data), 32'(exp_q[0].data));
    end
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_done", 32'(bus.sweep_done), 32'd0);
    chk("idle_cfg_err", 32'(bus.cfg_err), 32'd0);
    pop = (exp_q.size() != 0) && ordy;
    acc = iv && exp_rdy;
    tick();
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      r.idx = id; r.data = model[id]; r.swp = 1'b0;
      exp_q.push_back(r);
    end
    if (we) model[wa] = wd;
  endtask

  // Exhaustive sweep: optional same-cycle eval, optional rejected write, optional toggled ready.
  task automatic run_sweep(bit toggle, bit with_eval, bit with_wr);
    res_t       r;
    bit         err_exp, stalled, pop, last, done_seen;
    logic [3:0] prev_idx;
    logic [2:0] prev_data;
    int         cyc;
    err_exp = 0; stalled = 0; done_seen = 0; prev_idx = '0; prev_data = '0;
    bus.sweep_start = 1'b1; bus.in_valid = with_eval; bus.in_data = 4'h2;
    bus.out_ready = 1'b1; bus.cfg_we = 1'b0;
    #1;
    if (with_eval) chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    if (with_eval) begin
      r.idx = 4'h2; r.data = model[2]; r.swp = 1'b0;
      exp_q.push_back(r);
    end
    for (int i = 0; i < DEPTH; i++) begin
      r.idx = 4'(i); r.data = model[i]; r.swp = 1'b1;
      exp_q.push_back(r);
    end
    tick();
    bus.sweep_start = 1'b0; bus.in_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      bus.out_ready   = toggle ? cyc[0] : 1'b1;
      bus.cfg_we      = with_wr && (cyc == 3);
      bus.cfg_addr    = 4'h5;
      bus.cfg_data    = 3'b111;
      bus.sweep_start = toggle && (cyc == 5);
      #1;
      chk("sweep_cfg_err", 32'(bus.cfg_err), 32'(err_exp));
      chk("sweep_busy", 32'(bus.busy), 32'd1);
      chk("sweep_in_ready", 32'(bus.in_ready), 32'd0);
      if (stalled) begin
        chk("stall_index", 32'(bus.out_index), 32'(prev_idx));
        chk("stall_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid) begin
        chk("sweep_index", 32'(bus.out_index), 32'(exp_q[0].idx));
        chk("sweep_data", 32'(bus.out_data), 32'(exp_q[0].data));
      end
      pop  = bus.out_valid && bus.out_ready;
      last = (exp_q.size() == 1) && exp_q[0].swp;
      chk("sweep_done", 32'(bus.sweep_done), 32'(pop && last));
      if (bus.sweep_done) done_seen = 1;
      stalled   = bus.out_valid && !bus.out_ready;
      prev_idx  = bus.out_index;
      prev_data = bus.out_data;
      err_exp   = bus.cfg_we;
      tick();
      if (pop) void'(exp_q.pop_front());
      cyc++;
    end
    bus.cfg_we = 1'b0; bus.sweep_start = 1'b0; bus.out_ready = 1'b1;
    chk("sweep_all_results", 32'(exp_q.size()), 32'd0);
    chk("sweep_done_seen", 32'(done_seen), 32'd1);
    if (!toggle) chk("sweep_back_to_back_cycles", 32'(cyc), 32'd17);
    #1;
    chk("post_sweep_busy", 32'(bus.busy), 32'd0);
    chk("post_sweep_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit found;
    bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.in_valid = 0;
    bus.in_data = '0; bus.sweep_start = 0; bus.out_ready = 1;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
    chk("rst_sweep_done", 32'(bus.sweep_done), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    clear_model();

    // Program a[2:0] ^ {3{a[3]}}
    for (int a = 0; a < DEPTH; a++) begin
      logic [3:0] av;
      av = 4'(a);
      drive_cycle(0, 4'h0, 1, 1, av, av[2:0] ^ {3{av[3]}});
    end

    drive_cycle(1, 4'hB, 1, 0, 4'h0, 3'b000);
    chk("evalB_valid", 32'(bus.out_valid), 32'd1);
    chk("evalB_index", 32'(bus.out_index), 32'hB);
    chk("evalB_data", 32'(bus.out_data), 32'b100);
    drive_cycle(0, 4'h0, 1, 0, 4'h0, 3'b000);

    // Same-cycle write and eval of address 3: old value first
    drive_cycle(1, 4'h3, 1, 1, 4'h3, 3'b010);
    chk("rbw_old", 32'(bus.out_data), 32'b011);
    drive_cycle(1, 4'h3, 1, 0, 4'h0, 3'b000);
    chk("rbw_new", 32'(bus.out_data), 32'b010);
    drive_cycle(0, 4'h0, 1, 0, 4'h0, 3'b000);

    // Random evaluation with back-pressure and concurrent writes
    for (int i = 0; i < 80; i++)
      drive_cycle(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
    drive_cycle(0, 4'h0, 1, 0, 4'h0, 3'b000);

    run_sweep(0, 1, 1);
    run_sweep(1, 0, 0);
    drive_cycle(1, 4'h5, 1, 0, 4'h0, 3'b000);
    drive_cycle(0, 4'h0, 1, 0, 4'h0, 3'b000);

    // Reset in the middle of a sweep
    bus.sweep_start = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.sweep_start = 1'b0;
    found = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus.out_valid && bus.out_index == 4'h7) found = 1;
      else tick();
    end
    chk("midsweep_reached_7", 32'(found), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.sweep_done), 32'd0);
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 20; i++) drive_cycle(0, 4'h0, 1, 0, 4'h0, 3'b000);
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1, 4'($urandom_range(0, 15)), 1, 0, 4'h0, 3'b000);
      chk("post_rst_eval_zero", 32'(bus.out_data), 32'd0);
    end
    drive_cycle(0, 4'h0, 1, 0, 4'h0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
